// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - modulo-MAX up/down counter stepped by rising edges of a sampled divided clock
//
// Optional feature macro: TICK_COUNTER_SATURATE_EN
//   undefined : count wraps MAX->0 (up) and 0->MAX (down), wrap pulses on the wrap step
//   defined   : count holds at MAX (up) / 0 (down), the edge is rejected, wrap pulses
//
// Parameters:
//   WIDTH      count width in bits
//   MAX        highest count value, 1 <= MAX <= 2**WIDTH-1
//
// Ports:
//   clk_in     in   1      system clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   tick_in    in   1      divided clock, treated as an asynchronous level
//   en         in   1      count enable, sampled in the edge cycle
//   up_down    in   1      1 = increment, 0 = decrement
//   load       in   1      synchronous load strobe, wins over a coincident edge
//   load_value in   WIDTH  value to load, clamped to MAX
//   count      out  WIDTH  registered count
//   step       out  1      one-cycle pulse each time count advances
//   wrap       out  1      one-cycle pulse on wrap (or rejected edge when saturating)

module tick_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);
    // The clamp compare is done one bit wider so it stays meaningful when
    // MAX is the largest value representable in WIDTH bits.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             tick_edge;
    logic [WIDTH:0]   load_ext;
    logic             load_over;
    logic [WIDTH-1:0] count_nxt;
    logic             step_nxt;
    logic             wrap_nxt;

    // Synchronizer and history flops reset high so a tick_in that is already
    // high when reset releases is not mistaken for a rising edge.
    assign tick_edge = sync2 & ~prev;

    assign load_ext  = {1'b0, load_value};
    assign load_over = (load_ext > MAX_EXT);

    always_comb begin
        count_nxt = count;
        step_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = load_over ? MAX_V : load_value;
        end else if (tick_edge && en) begin
            if (up_down) begin
                if (count == MAX_V) begin
`ifdef TICK_COUNTER_SATURATE_EN
                    wrap_nxt  = 1'b1;
`else
                    count_nxt = '0;
                    step_nxt  = 1'b1;
                    wrap_nxt  = 1'b1;
`endif
                end else begin
                    count_nxt = count + ONE_V;
                    step_nxt  = 1'b1;
                end
            end else begin
                if (count == '0) begin
`ifdef TICK_COUNTER_SATURATE_EN
                    wrap_nxt  = 1'b1;
`else
                    count_nxt = MAX_V;
                    step_nxt  = 1'b1;
                    wrap_nxt  = 1'b1;
`endif
                end else begin
                    count_nxt = count - ONE_V;
                    step_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            count <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            sync1 <= tick_in;
            sync2 <= sync1;
            prev  <= sync2;
            count <= count_nxt;
            step  <= step_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule
